// File: rtl/load_scheduler_pkg.sv
// Shared definitions for the load scheduler: load indices, slot states, defaults.
// Slot state literals carry an ST_ prefix so they cannot collide with the COOL load index.
package load_scheduler_pkg;

  localparam int NUM_LOADS = 4;

  localparam int HEAT   = 0;
  localparam int COOL   = 1;
  localparam int PUMP   = 2;
  localparam int SPRINK = 3;

  localparam int DEF_MIN_ON      = 8;
  localparam int DEF_MIN_OFF     = 4;
  localparam int DEF_MAX_ACTIVE  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_COOL = 2'd2
  } slot_state_e;

  function automatic logic [2:0] count_ones(input logic [NUM_LOADS-1:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < NUM_LOADS; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/load_scheduler_if.sv
// Request/grant bundle between the load controller and the scheduler.
interface load_scheduler_if;
  import load_scheduler_pkg::*;

  logic [NUM_LOADS-1:0] req;
  logic                 fire;
  logic [NUM_LOADS-1:0] grant;
  logic [NUM_LOADS-1:0] waiting;
  logic [2:0]           active_cnt;

  modport master (output req, output fire, input grant, input waiting, input active_cnt);
  modport slave  (input req, input fire, output grant, output waiting, output active_cnt);
endinterface

// File: rtl/load_slot.sv
// One load's IDLE/RUN/COOL lifecycle with a shared 4-bit run/cooldown counter.
module load_slot
  import load_scheduler_pkg::*;
#(
  parameter int MIN_ON  = DEF_MIN_ON,
  parameter int MIN_OFF = DEF_MIN_OFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue,
  input  logic        req,
  input  logic        force_off,
  input  logic        force_on,
  output slot_state_e state,
  output logic        granted,
  output logic        releasing
);

  if (MIN_ON < 1 || MIN_ON > 15) begin : g_bad_min_on
    $error("load_slot: MIN_ON must be within 1..15");
  end
  if (MIN_OFF < 1 || MIN_OFF > 15) begin : g_bad_min_off
    $error("load_slot: MIN_OFF must be within 1..15");
  end

  slot_state_e r_state, w_state_next;
  logic [3:0]  r_cnt, w_cnt_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Forced-on holds the counter at 1, so leaving fire mode looks like a fresh grant.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (force_on) begin
      w_state_next = ST_RUN;
      w_cnt_next   = 4'd1;
    end else begin
      case (r_state)
        ST_IDLE: if (issue) begin
          w_state_next = ST_RUN;
          w_cnt_next   = 4'd1;
        end
        ST_RUN: if (releasing) begin
          w_state_next = ST_COOL;
          w_cnt_next   = 4'd1;
        end else if (r_cnt != 4'd15) begin
          w_cnt_next = r_cnt + 4'd1;
        end
        ST_COOL: if (r_cnt >= 4'(MIN_OFF)) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = 4'd0;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
        default: begin
          w_state_next = ST_IDLE;
          w_cnt_next   = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    granted   = (r_state == ST_RUN);
    releasing = granted && !force_on && (force_off || (!req && (r_cnt >= 4'(MIN_ON))));
  end

  assign state = r_state;

endmodule

// File: rtl/load_scheduler.sv
// Round-robin grant issuer with active-load budget, heat/cool exclusion and fire override.
module load_scheduler
  import load_scheduler_pkg::*;
#(
  parameter int MIN_ON     = DEF_MIN_ON,
  parameter int MIN_OFF    = DEF_MIN_OFF,
  parameter int MAX_ACTIVE = DEF_MAX_ACTIVE
) (
  input logic              clk,
  input logic              reset,
  load_scheduler_if.slave  bus
);

  slot_state_e          w_state [NUM_LOADS];
  logic [NUM_LOADS-1:0] w_granted, w_releasing, w_idle, w_cand, w_issue;
  logic [NUM_LOADS-1:0] w_force_off, w_force_on;
  logic [2:0]           w_run_after;
  logic                 w_budget_full, w_found;
  logic [1:0]           w_pick;

  logic [1:0]           r_ptr;
  logic [NUM_LOADS-1:0] r_grant, r_waiting;
  logic [2:0]           r_active_cnt;

  // Loads releasing this cycle free their budget slot immediately.
  assign w_run_after   = count_ones(w_granted & ~w_releasing);
  assign w_budget_full = (int'(w_run_after) >= MAX_ACTIVE);

  for (genvar gi = 0; gi < NUM_LOADS; gi++) begin : g_slot
    assign w_force_off[gi] = bus.fire && ((gi == HEAT) || (gi == COOL));
    assign w_force_on[gi]  = bus.fire && (gi == SPRINK);
    assign w_idle[gi]      = (w_state[gi] == ST_IDLE);
    assign w_cand[gi]      = w_idle[gi] && bus.req[gi]
                          && !(bus.fire && (gi != PUMP))
                          && !((gi == HEAT) && w_granted[COOL])
                          && !((gi == COOL) && w_granted[HEAT])
                          && !(w_budget_full && !(bus.fire && (gi == PUMP)));

    load_slot #(.MIN_ON(MIN_ON), .MIN_OFF(MIN_OFF)) u_slot (
      .clk       (clk),
      .reset     (reset),
      .issue     (w_issue[gi]),
      .req       (bus.req[gi]),
      .force_off (w_force_off[gi]),
      .force_on  (w_force_on[gi]),
      .state     (w_state[gi]),
      .granted   (w_granted[gi]),
      .releasing (w_releasing[gi])
    );
  end

  always_comb begin
    logic [1:0] idx;
    w_issue = '0;
    w_found = 1'b0;
    w_pick  = r_ptr;
    for (int k = 1; k <= NUM_LOADS; k++) begin
      idx = r_ptr + 2'(k);
      if (!w_found && w_cand[idx]) begin
        w_found = 1'b1;
        w_pick  = idx;
      end
    end
    if (w_found) w_issue[w_pick] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr        <= 2'd3;
      r_grant      <= '0;
      r_waiting    <= '0;
      r_active_cnt <= 3'd0;
    end else begin
      if (w_found) r_ptr <= w_pick;
      r_grant      <= w_granted;
      r_waiting    <= bus.req & w_idle;
      r_active_cnt <= count_ones(w_granted);
    end
  end

  assign bus.grant      = r_grant;
  assign bus.waiting    = r_waiting;
  assign bus.active_cnt = r_active_cnt;

endmodule

// File: tb/tb_load_scheduler.sv
// Directed scenarios plus random traffic, checked against a time-based model of the load rules.
module tb_load_scheduler;
  localparam int MIN_ON     = 8;
  localparam int MIN_OFF    = 4;
  localparam int MAX_ACTIVE = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  load_scheduler_if bus();

  load_scheduler #(.MIN_ON(MIN_ON), .MIN_OFF(MIN_OFF), .MAX_ACTIVE(MAX_ACTIVE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: a load is either on (with cycles-on age), cooling (cycles left), or free.
  bit   m_on   [4];
  int   m_age  [4];
  int   m_cool [4];
  int   m_ptr;
  logic [3:0] exp_grant, exp_wait;
  logic [2:0] exp_cnt;
  int n_assert = 0;
  int n_fail   = 0;
  int step_no  = 0;

  task automatic model_edge(input logic [3:0] rq, input logic fi, input logic rs);
    bit rel [4];
    int busy, pick, i;
    bit ok;
    exp_grant = '0; exp_wait = '0; exp_cnt = '0;
    for (int j = 0; j < 4; j++) begin
      exp_grant[j] = m_on[j];
      exp_wait[j]  = rq[j] && !m_on[j] && (m_cool[j] == 0);
      exp_cnt      = exp_cnt + 3'(m_on[j]);
    end
    if (rs) begin
      exp_grant = '0; exp_wait = '0; exp_cnt = '0;
      for (int j = 0; j < 4; j++) begin m_on[j] = 0; m_age[j] = 0; m_cool[j] = 0; end
      m_ptr = 3;
      return;
    end
    busy = 0;
    for (int j = 0; j < 4; j++) begin
      rel[j] = m_on[j] && !(fi && j == 3) && ((fi && j <= 1) || (!rq[j] && m_age[j] >= MIN_ON));
      if (m_on[j] && !rel[j]) busy++;
    end
    pick = -1;
    for (int k = 1; k <= 4; k++) begin
      i  = (m_ptr + k) % 4;
      ok = !m_on[i] && (m_cool[i] == 0) && rq[i];
      if (fi && i != 2) ok = 0;
      if (i == 0 && m_on[1]) ok = 0;
      if (i == 1 && m_on[0]) ok = 0;
      if (busy >= MAX_ACTIVE && !(fi && i == 2)) ok = 0;
      if (ok && pick < 0) pick = i;
    end
    if (pick >= 0) m_ptr = pick;
    for (int j = 0; j < 4; j++) begin
      if (fi && j == 3) begin
        m_on[j] = 1; m_age[j] = 1; m_cool[j] = 0;
      end else if (rel[j]) begin
        m_on[j] = 0; m_cool[j] = MIN_OFF;
      end else if (m_on[j]) begin
        if (m_age[j] < 15) m_age[j]++;
      end else if (m_cool[j] > 0) begin
        m_cool[j]--;
      end else if (j == pick) begin
        m_on[j] = 1; m_age[j] = 1;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    n_assert++;
    assert (bus.grant === exp_grant) else begin
      n_fail++;
      $error("FAIL %s.grant step=%0d observed=%b expected=%b", tag, step_no, bus.grant, exp_grant);
    end
    n_assert++;
    assert (bus.waiting === exp_wait) else begin
      n_fail++;
      $error("FAIL %s.waiting step=%0d observed=%b expected=%b", tag, step_no, bus.waiting, exp_wait);
    end
    n_assert++;
    assert (bus.active_cnt === exp_cnt) else begin
      n_fail++;
      $error("FAIL %s.active_cnt step=%0d observed=%0d expected=%0d", tag, step_no, bus.active_cnt, exp_cnt);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] rq, input logic fi, input logic rs);
    @(negedge clk);
    bus.req = rq;
    bus.fire = fi;
    reset = rs;
    @(posedge clk);
    model_edge(rq, fi, rs);
    #1;
    step_no++;
    $display("step %0d %s req=%b fire=%b rst=%b grant=%b waiting=%b active=%0d",
             step_no, tag, rq, fi, rs, bus.grant, bus.waiting, bus.active_cnt);
    check_outputs(tag);
  endtask

  initial begin
    int  hi;
    bit  fire_r;
    bus.req = '0;
    bus.fire = 1'b0;

    step("reset", 4'b0000, 1'b0, 1'b1);

    hi = 0;
    repeat (3) begin step("latency", 4'b0001, 1'b0, 1'b0); if (bus.grant[0]) hi++; end
    repeat (16) begin step("latency", 4'b0000, 1'b0, 1'b0); if (bus.grant[0]) hi++; end
    n_assert++;
    assert (hi === MIN_ON) else begin
      n_fail++;
      $error("FAIL min_on_hold observed=%0d expected=%0d", hi, MIN_ON);
    end
    repeat (3) step("regrant", 4'b0001, 1'b0, 1'b0);

    step("reset", 4'b0000, 1'b0, 1'b1);
    repeat (12) begin
      step("budget", 4'b1111, 1'b0, 1'b0);
      n_assert++;
      assert (bus.active_cnt <= 3'(MAX_ACTIVE)) else begin
        n_fail++;
        $error("FAIL budget_cap observed=%0d expected<=%0d", bus.active_cnt, MAX_ACTIVE);
      end
    end

    step("reset", 4'b0000, 1'b0, 1'b1);
    repeat (10) step("fire_setup", 4'b1001, 1'b0, 1'b0);
    repeat (3) step("swap", 4'b0101, 1'b0, 1'b0);
    repeat (3) step("fire", 4'b0101, 1'b1, 1'b0);
    n_assert++;
    assert (bus.grant[3] === 1'b1) else begin
      n_fail++;
      $error("FAIL fire_sprinkler observed=%b expected=1", bus.grant[3]);
    end
    repeat (14) step("fire_exit", 4'b0000, 1'b0, 1'b0);

    step("reset", 4'b0000, 1'b0, 1'b1);
    repeat (4) step("mid_run", 4'b0001, 1'b0, 1'b0);
    step("mid_reset", 4'b0001, 1'b0, 1'b1);
    repeat (3) step("post_reset", 4'b1111, 1'b0, 1'b0);

    fire_r = 1'b0;
    repeat (400) begin
      if ($urandom_range(0, 24) == 0) fire_r = ~fire_r;
      step("random", 4'($urandom_range(0, 15)), fire_r, ($urandom_range(0, 99) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at step %0d", step_no);
    $fatal(1, "watchdog");
  end

endmodule
